// File: rtl/fifo_pop_stage_if.sv
// Handshake bundle between the FIFO drain stage, the upstream FIFO read side
// and the downstream valid/ready consumer.
interface fifo_pop_stage_if #(
  parameter int DWIDTH = 32
) ();

  logic [DWIDTH-1:0] fifo_outData;
  logic              fifo_empty;
  logic              single_pop;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;

  // master is the drain stage itself
  modport master (
    input  fifo_outData,
    input  fifo_empty,
    input  out_ready,
    output single_pop,
    output out_valid,
    output out_data
  );

  // slave is the environment: FIFO read port plus consumer
  modport slave (
    output fifo_outData,
    output fifo_empty,
    output out_ready,
    input  single_pop,
    input  out_valid,
    input  out_data
  );

endinterface

// File: rtl/fifo_pop_stage.sv
// Drain stage behind the flopped FIFO: pops from registered occupancy only and
// buffers read data in a main+skid pair so out_ready never reaches single_pop.
module fifo_pop_stage #(
  parameter int DWIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  fifo_pop_stage_if.master bus,
  output logic             stage_idle
);

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_FULL  = 2'd2;

  logic [1:0]        cnt_q;
  logic [1:0]        cnt_d;
  logic [DWIDTH-1:0] main_q;
  logic [DWIDTH-1:0] main_d;
  logic [DWIDTH-1:0] skid_q;
  logic [DWIDTH-1:0] skid_d;
  logic              pop;
  logic              acc;
  logic              out_valid;

  // The skid entry guarantees room for the word already in flight, so the
  // pop decision can rely on registered occupancy alone.
  always_comb begin
    pop       = !rst && !flush && !bus.fifo_empty && (cnt_q != CNT_FULL);
    out_valid = (cnt_q != CNT_EMPTY);
    acc       = out_valid && bus.out_ready;
  end

  always_comb begin
    cnt_d  = cnt_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      cnt_d = CNT_EMPTY;
    end else begin
      case (cnt_q)
        CNT_EMPTY: begin
          if (pop) begin
            cnt_d  = CNT_ONE;
            main_d = bus.fifo_outData;
          end
        end
        CNT_ONE: begin
          if (pop && acc) begin
            main_d = bus.fifo_outData;
          end else if (pop) begin
            cnt_d  = CNT_FULL;
            skid_d = bus.fifo_outData;
          end else if (acc) begin
            cnt_d = CNT_EMPTY;
          end
        end
        CNT_FULL: begin
          if (acc) begin
            cnt_d  = CNT_ONE;
            main_d = skid_q;
          end
        end
        default: begin
          cnt_d = CNT_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= CNT_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign bus.single_pop = pop;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = main_q;
  assign stage_idle     = (cnt_q == CNT_EMPTY) && bus.fifo_empty;

  a_no_pop_when_empty: assert property (
    @(posedge clk) disable iff (rst) !(bus.single_pop && bus.fifo_empty));

  a_cnt_legal: assert property (
    @(posedge clk) disable iff (rst) cnt_q != 2'd3);

  a_data_stable_under_backpressure: assert property (
    @(posedge clk) disable iff (rst)
      (out_valid && !bus.out_ready && !flush) |=> $stable(main_q));

endmodule

// File: tb/tb_fifo_pop_stage.sv
// Directed bench for fifo_pop_stage: a queue stands in for the upstream FIFO
// and every cycle's pop/valid/data is compared against hand-derived values.
module tb_fifo_pop_stage;

  logic clk;
  logic rst;
  logic flush;
  logic stage_idle;

  fifo_pop_stage_if #(.DWIDTH(32)) bus ();

  fifo_pop_stage #(.DWIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (bus),
    .stage_idle (stage_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] fifo_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          occ      = 0;
  logic        s_pop;
  logic        s_valid;
  logic        s_acc;
  logic        s_idle;
  logic [31:0] s_data;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs shortly after the edge, sample, then let the
  // edge commit and retire the popped word from the FIFO model.
  task automatic applyStimulus(input bit ready, input bit fl);
    bus.out_ready    = ready;
    flush            = fl;
    bus.fifo_empty   = (fifo_q.size() == 0);
    bus.fifo_outData = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
    #1;
    s_pop   = bus.single_pop;
    s_valid = bus.out_valid;
    s_data  = bus.out_data;
    s_idle  = stage_idle;
    s_acc   = bus.out_valid && ready;
    @(posedge clk);
    #1;
    if (s_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (fl) occ = 0;
    else    occ = occ + int'(s_pop) - int'(s_acc);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, got %0d checks, expected completion", n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pops;
    int next_push;
    int next_exp;
    int got;
    int occ_before;
    logic [31:0] exp_d1 [5];
    bit          exp_p1 [5];
    bit          exp_v1 [5];

    rst              = 1'b1;
    flush            = 1'b0;
    bus.out_ready    = 1'b0;
    fifo_q           = '{32'h11, 32'h22, 32'h33};
    bus.fifo_empty   = 1'b0;
    bus.fifo_outData = 32'h11;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_valid", 32'(bus.out_valid), 0);
    checkOutput("rst_data", bus.out_data, 0);
    checkOutput("rst_pop", 32'(bus.single_pop), 0);
    checkOutput("rst_idle", 32'(stage_idle), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] test 1: streaming three words");
    exp_p1 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_v1 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_d1 = '{32'h0, 32'h11, 32'h22, 32'h33, 32'h0};
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput($sformatf("t1_pop_c%0d", c), 32'(s_pop), 32'(exp_p1[c]));
      checkOutput($sformatf("t1_valid_c%0d", c), 32'(s_valid), 32'(exp_v1[c]));
      if (exp_v1[c]) checkOutput($sformatf("t1_data_c%0d", c), s_data, exp_d1[c]);
    end
    checkOutput("t1_idle_c4", 32'(s_idle), 1);

    $display("[TB] test 2: backpressure then drain");
    fifo_q = '{32'h100, 32'h101, 32'h102, 32'h103};
    pops   = 0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 1'b0);
      pops += int'(s_pop);
      if (c >= 1) checkOutput($sformatf("t2_hold_c%0d", c), s_data, 32'h100);
      if (c >= 2) checkOutput($sformatf("t2_pop_full_c%0d", c), 32'(s_pop), 0);
    end
    checkOutput("t2_pops", pops, 2);
    checkOutput("t2_fifo_left", fifo_q.size(), 2);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput($sformatf("t2_valid_%0d", c), 32'(s_valid), 1);
      checkOutput($sformatf("t2_word_%0d", c), s_data, 32'h100 + c);
    end
    applyStimulus(1'b1, 1'b0);
    checkOutput("t2_valid_end", 32'(s_valid), 0);

    $display("[TB] test 3: toggling ready over 100 words");
    next_push = 32'h1000;
    next_exp  = 32'h1000;
    got       = 0;
    for (int c = 0; c < 400 && got < 100; c++) begin
      while (fifo_q.size() < 4) begin
        fifo_q.push_back(next_push);
        next_push++;
      end
      occ_before = occ;
      applyStimulus((c % 2) == 0, 1'b0);
      if (occ_before == 2) checkOutput("t3_pop_full", 32'(s_pop), 0);
      if (s_acc) begin
        checkOutput("t3_order", s_data, next_exp);
        next_exp++;
        got++;
      end
    end
    checkOutput("t3_count", got, 100);
    applyStimulus(1'b0, 1'b1);
    fifo_q.delete();
    applyStimulus(1'b0, 1'b0);
    checkOutput("t3_flushed", 32'(s_valid), 0);

    $display("[TB] test 4: flush while full");
    fifo_q = '{32'hA, 32'hB, 32'hC};
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t4_full_valid", 32'(s_valid), 1);
    checkOutput("t4_full_data", s_data, 32'hA);
    checkOutput("t4_full_pop", 32'(s_pop), 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t4_flush_pop", 32'(s_pop), 0);
    checkOutput("t4_flush_valid", 32'(s_valid), 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t4_after_valid", 32'(s_valid), 0);
    checkOutput("t4_after_pop", 32'(s_pop), 1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t4_resume_valid", 32'(s_valid), 1);
    checkOutput("t4_resume_data", s_data, 32'hC);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t4_drained", 32'(s_valid), 0);

    $display("[TB] test 5: reset while full");
    fifo_q = '{32'h51, 32'h52, 32'h53};
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_valid", 32'(bus.out_valid), 0);
    checkOutput("t5_rst_data", bus.out_data, 0);
    checkOutput("t5_rst_pop", 32'(bus.single_pop), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    occ = 0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("t5_rel_pop", 32'(s_pop), 1);
    checkOutput("t5_rel_valid", 32'(s_valid), 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t5_first_valid", 32'(s_valid), 1);
    checkOutput("t5_first_data", s_data, 32'h53);
    applyStimulus(1'b1, 1'b0);

    $display("[TB] test 6: FIFO empty throughout");
    fifo_q.delete();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput($sformatf("t6_pop_c%0d", c), 32'(s_pop), 0);
      checkOutput($sformatf("t6_valid_c%0d", c), 32'(s_valid), 0);
      checkOutput($sformatf("t6_idle_c%0d", c), 32'(s_idle), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
